bp_be_mmu_cmd_fifo: RTL and testbench

Command queue between the memory pipe and the D-cache/MMU. The memory pipe emits one MMU command per cycle without observing backpressure. This block buffers those commands in a small circular FIFO, presents them in order to the D-cache with a valid/yumi handshake, and supports two kinds of squash: a full flush, and cancellation of the most recently enqueued command (late kill of the instruction that entered the previous cycle).

---
 rtl/bp_be_mmu_cmd_fifo_if.sv | 32 +++
 rtl/bp_be_mmu_cmd_fifo.sv | 104 ++++++++++
 tb/tb_bp_be_mmu_cmd_fifo.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/bp_be_mmu_cmd_fifo_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | bp_be_mmu_cmd_fifo_if : producer/consumer bundle of the MMU cmd queue  |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
interface bp_be_mmu_cmd_fifo_if #(
  parameter int els_p       = 4,
  parameter int cmd_width_p = 112
);
  localparam int count_width_lp = $clog2(els_p + 1);

  logic [cmd_width_p-1:0]    cmd_i;
  logic                      cmd_v_i;
  logic                      cmd_ready_o;
  logic                      kill_last_i;
  logic                      flush_i;
  logic [cmd_width_p-1:0]    cmd_o;
  logic                      cmd_v_o;
  logic                      cmd_yumi_i;
  logic [count_width_lp-1:0] count_o;

  modport slave (
    input  cmd_i, cmd_v_i, kill_last_i, flush_i, cmd_yumi_i,
    output cmd_ready_o, cmd_o, cmd_v_o, count_o
  );

  modport master (
    output cmd_i, cmd_v_i, kill_last_i, flush_i, cmd_yumi_i,
    input  cmd_ready_o, cmd_o, cmd_v_o, count_o
  );
endinterface
`default_nettype wire

// File: rtl/bp_be_mmu_cmd_fifo.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | bp_be_mmu_cmd_fifo : circular MMU command queue with flush/kill-last   |
// | Option macro: BP_BE_MMU_CMD_FIFO_BYPASS_EN (empty-queue bypass)  Rev 1.0 |
// +------------------------------------------------------------------------+
module bp_be_mmu_cmd_fifo #(
  parameter int els_p       = 4,
  parameter int cmd_width_p = 112
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  bp_be_mmu_cmd_fifo_if.slave    fifo_if
);

  localparam int ptr_width_lp   = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int count_width_lp = $clog2(els_p + 1);
  localparam logic [ptr_width_lp-1:0]   ptr_max_lp    = ptr_width_lp'(els_p - 1);
  localparam logic [count_width_lp-1:0] count_full_lp = count_width_lp'(els_p);
  localparam logic [count_width_lp-1:0] count_one_lp  = count_width_lp'(1);

  function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
    return (p == ptr_max_lp) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [ptr_width_lp-1:0] ptr_dec(input logic [ptr_width_lp-1:0] p);
    return (p == '0) ? ptr_max_lp : p - 1'b1;
  endfunction

  logic [cmd_width_p-1:0]    mem_q [els_p];
  logic [ptr_width_lp-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ptr_width_lp-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ptr_width_lp-1:0]   wr_addr;
  logic [count_width_lp-1:0] count_q, count_d;
  logic                      last_v_q, last_v_d;

  logic empty, full, kill, ready, enq, store, deq, bypass, queue_v;

  assign empty = (count_q == '0);
  assign full  = (count_q == count_full_lp);
  assign kill  = fifo_if.kill_last_i & last_v_q;
  assign ready = ~full & ~reset_i;
  assign enq   = fifo_if.cmd_v_i & ready;

  // A head that is being killed this cycle must not be handed out.
  assign queue_v = ~empty & ~(kill & (count_q == count_one_lp)) & ~reset_i;
  assign deq     = fifo_if.cmd_yumi_i & queue_v;

`ifdef BP_BE_MMU_CMD_FIFO_BYPASS_EN
  assign bypass        = empty & fifo_if.cmd_v_i & ~fifo_if.flush_i & ~reset_i;
  assign fifo_if.cmd_o = bypass ? fifo_if.cmd_i : mem_q[rd_ptr_q];
`else
  assign bypass        = 1'b0;
  assign fifo_if.cmd_o = mem_q[rd_ptr_q];
`endif

  // A bypassed command taken in the same cycle never occupies a slot.
  assign store   = enq & ~fifo_if.flush_i & ~(bypass & fifo_if.cmd_yumi_i);
  assign wr_addr = kill ? ptr_dec(wr_ptr_q) : wr_ptr_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    last_v_d = 1'b0;
    if (fifo_if.flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = deq   ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      wr_ptr_d = store ? ptr_inc(wr_addr)  : wr_addr;
      count_d  = count_q + count_width_lp'(store)
                         - count_width_lp'(deq)
                         - count_width_lp'(kill);
      last_v_d = store;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      last_v_q <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      last_v_q <= last_v_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (store) begin
      mem_q[wr_addr] <= fifo_if.cmd_i;
    end
  end

  assign fifo_if.cmd_ready_o = ready;
  assign fifo_if.cmd_v_o     = bypass | queue_v;
  assign fifo_if.count_o     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_bp_be_mmu_cmd_fifo.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_bp_be_mmu_cmd_fifo : directed checks of the MMU command queue       |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_bp_be_mmu_cmd_fifo;

  localparam int ELS = 4;
  localparam int W   = 112;

  logic clk_i = 1'b0;
  logic reset_i;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk_i = ~clk_i;

  bp_be_mmu_cmd_fifo_if #(.els_p(ELS), .cmd_width_p(W)) fifo_if ();

  bp_be_mmu_cmd_fifo #(.els_p(ELS), .cmd_width_p(W)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .fifo_if (fifo_if)
  );

  function automatic logic [W-1:0] mk(input int i);
    return {16'hC0DE, 64'h0, 32'(i)};
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic y,
                       input logic k, input logic f);
    fifo_if.cmd_v_i     = v;
    fifo_if.cmd_i       = d;
    fifo_if.cmd_yumi_i  = y;
    fifo_if.kill_last_i = k;
    fifo_if.flush_i     = f;
  endtask

  initial begin
    reset_i = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    check("rst_ready", fifo_if.cmd_ready_o, 0);
    check("rst_v",     fifo_if.cmd_v_o, 0);
    check("rst_count", fifo_if.count_o, 0);
    reset_i = 1'b0;
    #1;
    check("post_rst_ready", fifo_if.cmd_ready_o, 1);
    check("post_rst_v",     fifo_if.cmd_v_o, 0);
    check("post_rst_count", fifo_if.count_o, 0);

    // In-order enqueue of A,B,C then drain.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, mk(i), 1'b0, 1'b0, 1'b0);
      tick();
      check("t1_fill_count", fifo_if.count_o, i + 1);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      #1;
      check("t1_head", fifo_if.cmd_o, mk(i));
      check("t1_v",    fifo_if.cmd_v_o, 1);
      tick();
      check("t1_drain_count", fifo_if.count_o, 2 - i);
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    check("t1_empty_v", fifo_if.cmd_v_o, 0);

    // Fill, no enqueue while full, then streaming across pointer wrap.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, mk(16 + i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    check("t2_full_count", fifo_if.count_o, 4);
    drive(1'b1, mk(99), 1'b1, 1'b0, 1'b0);
    #1;
    check("t2_full_ready", fifo_if.cmd_ready_o, 0);
    check("t2_full_head",  fifo_if.cmd_o, mk(16));
    tick();
    check("t2_no_enq_count", fifo_if.count_o, 3);
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, mk(20 + k), 1'b1, 1'b0, 1'b0);
      #1;
      check("t2_stream_head",  fifo_if.cmd_o, mk(17 + k));
      check("t2_stream_ready", fifo_if.cmd_ready_o, 1);
      tick();
      check("t2_stream_count", fifo_if.count_o, 3);
    end
    for (int j = 0; j < 3; j++) begin
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      #1;
      check("t2_drain_head", fifo_if.cmd_o, mk(23 + j));
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("t2_drain_count", fifo_if.count_o, 0);

    // Kill X while enqueueing Y: Y reuses the reclaimed slot.
    drive(1'b1, mk(30), 1'b0, 1'b0, 1'b0);
    tick();
    check("t3_x_count", fifo_if.count_o, 1);
    drive(1'b1, mk(31), 1'b0, 1'b1, 1'b0);
    #1;
    check("t3_kill_v", fifo_if.cmd_v_o, 0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    check("t3_y_count", fifo_if.count_o, 1);
    check("t3_y_head",  fifo_if.cmd_o, mk(31));
    check("t3_y_v",     fifo_if.cmd_v_o, 1);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    tick();
    check("t3_drain_count", fifo_if.count_o, 0);

    // Kill with nothing enqueued last cycle is ignored.
    drive(1'b1, mk(32), 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    #1;
    check("t3_stale_kill_v", fifo_if.cmd_v_o, 1);
    tick();
    check("t3_stale_kill_count", fifo_if.count_o, 1);
    check("t3_stale_kill_head",  fifo_if.cmd_o, mk(32));
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    tick();

    // Simultaneous enqueue, dequeue and kill.
    drive(1'b1, mk(40), 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, mk(41), 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, mk(42), 1'b1, 1'b1, 1'b0);
    #1;
    check("t3b_head", fifo_if.cmd_o, mk(40));
    check("t3b_v",    fifo_if.cmd_v_o, 1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    check("t3b_count",    fifo_if.count_o, 1);
    check("t3b_new_head", fifo_if.cmd_o, mk(42));
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    tick();
    check("t3b_drain_count", fifo_if.count_o, 0);

    // Flush with concurrent enqueue and yumi.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, mk(50 + i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, mk(53), 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    check("t4_flush_count", fifo_if.count_o, 0);
    check("t4_flush_v",     fifo_if.cmd_v_o, 0);
    drive(1'b1, mk(54), 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    check("t4_z_head",  fifo_if.cmd_o, mk(54));
    check("t4_z_v",     fifo_if.cmd_v_o, 1);
    check("t4_z_count", fifo_if.count_o, 1);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Reset in mid-stream.
    drive(1'b1, mk(60), 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, mk(61), 1'b0, 1'b0, 1'b0);
    tick();
    check("t5_pre_count", fifo_if.count_o, 2);
    reset_i = 1'b1;
    drive(1'b1, mk(62), 1'b0, 1'b0, 1'b0);
    #1;
    check("t5_rst_ready", fifo_if.cmd_ready_o, 0);
    check("t5_rst_v",     fifo_if.cmd_v_o, 0);
    tick();
    check("t5_rst_count", fifo_if.count_o, 0);
    reset_i = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    check("t5_post_v",     fifo_if.cmd_v_o, 0);
    check("t5_post_ready", fifo_if.cmd_ready_o, 1);

    // Empty queue, command with yumi in the same cycle.
    drive(1'b1, W'(8'h5A), 1'b1, 1'b0, 1'b0);
    #1;
`ifdef BP_BE_MMU_CMD_FIFO_BYPASS_EN
    check("t6_byp_v",    fifo_if.cmd_v_o, 1);
    check("t6_byp_head", fifo_if.cmd_o, W'(8'h5A));
    tick();
    check("t6_byp_count", fifo_if.count_o, 0);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    #1;
    check("t6_kill_v", fifo_if.cmd_v_o, 0);
    tick();
    check("t6_kill_count", fifo_if.count_o, 0);
`else
    check("t6_nobyp_v", fifo_if.cmd_v_o, 0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    check("t6_late_head",  fifo_if.cmd_o, W'(8'h5A));
    check("t6_late_v",     fifo_if.cmd_v_o, 1);
    check("t6_late_count", fifo_if.count_o, 1);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    tick();
    check("t6_drain_count", fifo_if.count_o, 0);
`endif
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
